// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter onto a single SRAM-like slave port: data side has priority,
// a stalled grant is locked until accepted, and responses are routed by an in-order owner FIFO.
module sram_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,

  output logic        err_spurious
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] OWNER_INST = 1'b0;
  localparam logic [0:0] OWNER_DATA = 1'b1;

  logic                       lock_valid_q, lock_valid_d;
  logic                       lock_owner_q, lock_owner_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       err_q, err_d;
  logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;

  logic grant;
  logic granted_req;
  logic full;
  logic count_nz;
  logic head;
  logic push;
  logic pop;

  // A stalled request keeps its grant so the slave never sees fields change under it.
  assign grant       = lock_valid_q ? lock_owner_q : (data_req ? OWNER_DATA : OWNER_INST);
  assign granted_req = (grant == OWNER_DATA) ? data_req : inst_req;
  assign full        = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign bus_req     = granted_req && !full && !reset;

  always_comb begin
    bus_wr    = 1'b0;
    bus_size  = 2'd2;
    bus_wstrb = 4'h0;
    bus_addr  = inst_addr;
    bus_wdata = 32'h0;
    if (grant == OWNER_DATA) begin
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_wstrb = data_wstrb;
      bus_addr  = data_addr;
      bus_wdata = data_wdata;
    end
  end

  assign push = bus_req && bus_addr_ok;
  assign inst_addr_ok = push && (grant == OWNER_INST);
  assign data_addr_ok = push && (grant == OWNER_DATA);

  // Count is treated as zero while reset is held so no response leaks out.
  assign count_nz = (count_q != '0) && !reset;
  assign head     = owner_q[rd_ptr_q];
  assign pop      = bus_data_ok && count_nz;

  assign inst_data_ok = pop && (head == OWNER_INST);
  assign data_data_ok = pop && (head == OWNER_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;
  assign err_spurious = err_q && !reset;

  generate
    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_owner
      assign owner_d[gi] = (push && (wr_ptr_q == PTR_W'(gi))) ? grant : owner_q[gi];
    end
  endgenerate

  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    if (push) begin
      lock_valid_d = 1'b0;
    end else if (bus_req) begin
      lock_valid_d = 1'b1;
      lock_owner_d = grant;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    err_d = err_q || (bus_data_ok && (count_q == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  // Owner slots need no reset: only entries behind a valid count are ever read.
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed plus randomized bench for sram_bus_arbiter, checked against a queue-based
// model of outstanding owners and a pending-request record.
module tb_sram_bus_arbiter;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        err_spurious;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owners of accepted-but-unanswered requests, oldest first.
  bit m_q[$];
  bit m_pend_v, m_pend_o, m_err;
  bit e_grant, e_breq, e_iaok, e_daok, e_idok, e_ddok;
  bit last_iaok, last_daok;

  sram_bus_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Let inputs settle, then compare every output with what the model predicts.
  task automatic settle();
    bit req_g;
    #4;
    e_grant = m_pend_v ? m_pend_o : data_req;
    req_g   = e_grant ? data_req : inst_req;
    e_breq  = req_g && (m_q.size() < MAXO) && !reset;
    e_iaok  = bus_addr_ok && e_breq && !e_grant;
    e_daok  = bus_addr_ok && e_breq && e_grant;
    e_idok  = bus_data_ok && !reset && (m_q.size() != 0) && (m_q[0] == 1'b0);
    e_ddok  = bus_data_ok && !reset && (m_q.size() != 0) && (m_q[0] == 1'b1);
    chk("bus_req", {31'b0, bus_req}, {31'b0, e_breq});
    chk("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, e_iaok});
    chk("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, e_daok});
    chk("inst_data_ok", {31'b0, inst_data_ok}, {31'b0, e_idok});
    chk("data_data_ok", {31'b0, data_data_ok}, {31'b0, e_ddok});
    chk("err_spurious", {31'b0, err_spurious}, {31'b0, m_err && !reset});
    chk("bus_addr", bus_addr, e_grant ? data_addr : inst_addr);
    chk("bus_wr", {31'b0, bus_wr}, {31'b0, e_grant ? data_wr : 1'b0});
    chk("bus_size", {30'b0, bus_size}, {30'b0, e_grant ? data_size : 2'd2});
    chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, e_grant ? data_wstrb : 4'h0});
    chk("bus_wdata", bus_wdata, e_grant ? data_wdata : 32'h0);
    if (e_idok) chk("inst_rdata", inst_rdata, bus_rdata);
    if (e_ddok) chk("data_rdata", data_rdata, bus_rdata);
  endtask

  task automatic advance();
    bit pop;
    pop = e_idok || e_ddok;
    if (reset) begin
      m_q.delete();
      m_pend_v = 1'b0;
      m_err    = 1'b0;
    end else begin
      if (bus_data_ok && m_q.size() == 0) m_err = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (e_breq && bus_addr_ok) begin
        m_q.push_back(e_grant);
        m_pend_v = 1'b0;
      end else if (e_breq) begin
        m_pend_v = 1'b1;
        m_pend_o = e_grant;
      end
    end
    last_iaok = e_iaok;
    last_daok = e_daok;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic idle();
    inst_req = 1'b0; data_req = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
  endtask

  initial begin
    reset = 1'b1; idle();
    inst_addr = 32'h0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0; bus_rdata = 32'h0;

    // Reset state, with stray activity on every input
    bus_data_ok = 1'b1; inst_req = 1'b1; bus_addr_ok = 1'b1;
    settle();
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_err", {31'b0, err_spurious}, 32'd0);
    advance();
    cycle();
    reset = 1'b0; idle();

    // Single inst read
    inst_req = 1'b1; inst_addr = 32'h1c000000; bus_addr_ok = 1'b1;
    settle(); chk("single_aok", {31'b0, inst_addr_ok}, 32'd1); advance();
    idle();
    settle(); chk("single_wait", {31'b0, inst_data_ok}, 32'd0); advance();
    bus_data_ok = 1'b1; bus_rdata = 32'h02800c21;
    settle();
    chk("single_dok", {31'b0, inst_data_ok}, 32'd1);
    chk("single_rdata", inst_rdata, 32'h02800c21);
    chk("single_no_data", {31'b0, data_data_ok}, 32'd0);
    advance();
    idle();

    // Contention: data wins, inst follows, responses in order
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hf;
    data_addr = 32'h1c008000; data_wdata = 32'h12345678;
    inst_req = 1'b1; inst_addr = 32'h1c000004; bus_addr_ok = 1'b1;
    settle();
    chk("cont_data_aok", {31'b0, data_addr_ok}, 32'd1);
    chk("cont_addr0", bus_addr, 32'h1c008000);
    chk("cont_wstrb", {28'b0, bus_wstrb}, 32'hf);
    advance();
    data_req = 1'b0;
    settle();
    chk("cont_inst_aok", {31'b0, inst_addr_ok}, 32'd1);
    chk("cont_addr1", bus_addr, 32'h1c000004);
    advance();
    idle(); bus_data_ok = 1'b1; bus_rdata = 32'h0000aaaa;
    settle(); chk("cont_resp_data", {31'b0, data_data_ok}, 32'd1); advance();
    bus_rdata = 32'hdeadbeef;
    settle(); chk("cont_resp_inst", {31'b0, inst_data_ok}, 32'd1); advance();
    idle();

    // Lock hold: stalled inst keeps the bus while data waits
    inst_req = 1'b1; inst_addr = 32'h1c000040;
    settle(); chk("lock_c0", bus_addr, 32'h1c000040); advance();
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'h0;
    data_addr = 32'h1c008010; data_wdata = 32'h0;
    settle(); chk("lock_c1", bus_addr, 32'h1c000040); advance();
    settle(); chk("lock_c2", bus_addr, 32'h1c000040); advance();
    bus_addr_ok = 1'b1;
    settle();
    chk("lock_c3", bus_addr, 32'h1c000040);
    chk("lock_c3_aok", {31'b0, inst_addr_ok}, 32'd1);
    advance();
    inst_req = 1'b0;
    settle();
    chk("lock_c4", bus_addr, 32'h1c008010);
    chk("lock_c4_aok", {31'b0, data_addr_ok}, 32'd1);
    advance();
    idle(); bus_data_ok = 1'b1;
    cycle(); cycle();
    idle();

    // Full: four accepted reads block the fifth until a response frees a slot
    inst_req = 1'b1; bus_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'h1c000100 + 32'(4 * i);
      settle(); chk("full_accept", {31'b0, inst_addr_ok}, 32'd1); advance();
    end
    inst_addr = 32'h1c000110; bus_data_ok = 1'b1; bus_rdata = 32'h11110000;
    settle(); chk("full_blocks", {31'b0, bus_req}, 32'd0); advance();
    bus_data_ok = 1'b0;
    settle(); chk("full_reenable", {31'b0, bus_req}, 32'd1); advance();
    idle(); bus_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_rdata = 32'h22220000 + 32'(i);
      cycle();
    end
    idle();

    // Spurious response
    bus_data_ok = 1'b1;
    settle();
    chk("spur_no_idok", {31'b0, inst_data_ok}, 32'd0);
    chk("spur_no_ddok", {31'b0, data_data_ok}, 32'd0);
    advance();
    idle();
    settle(); chk("spur_sticky", {31'b0, err_spurious}, 32'd1); advance();

    // Reset with two outstanding requests
    inst_req = 1'b1; inst_addr = 32'h1c000200; bus_addr_ok = 1'b1;
    cycle(); cycle();
    reset = 1'b1; bus_addr_ok = 1'b0;
    settle(); chk("midrst_bus_req", {31'b0, bus_req}, 32'd0); advance();
    reset = 1'b0; bus_addr_ok = 1'b1; inst_addr = 32'h1c000300;
    settle(); chk("post_rst_aok", {31'b0, inst_addr_ok}, 32'd1); advance();
    idle(); bus_data_ok = 1'b1; bus_rdata = 32'h0badcafe;
    settle();
    chk("post_rst_dok", {31'b0, inst_data_ok}, 32'd1);
    chk("post_rst_err", {31'b0, err_spurious}, 32'd0);
    advance();
    idle();

    // Randomized traffic; requesters hold fields until accepted
    last_iaok = 1'b0; last_daok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!(inst_req && !last_iaok)) begin
        inst_req  = ($urandom_range(0, 1) == 1);
        inst_addr = $urandom & 32'hffff_fffc;
      end
      if (!(data_req && !last_daok)) begin
        data_req   = ($urandom_range(0, 1) == 1);
        data_wr    = ($urandom_range(0, 1) == 1);
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      bus_addr_ok = ($urandom_range(0, 3) != 0);
      bus_data_ok = (m_q.size() != 0) ? ($urandom_range(0, 1) == 1)
                                      : ($urandom_range(0, 39) == 0);
      bus_rdata   = $urandom;
      reset       = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Shares one SRAM-like slave port between the IF-stage instruction requester and the MEM-stage data requester. It grants one request per address handshake and holds that grant stable until the slave accepts it. Each accepted request's owner is queued in order so the in-order `data_ok` responses are routed back to the right requester. The block sits between the pipeline's `inst_sram_*`/`data_sram_*` ports and the single bus (or AXI bridge) port.

## Interface
- MAX_OUTSTANDING, 4: max accepted-but-unanswered requests. Must be 2, 4 or 8 (power of two).
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- inst_req  in  1  instruction read request (always read, size 2, wstrb 0)
- inst_addr  in  32  instruction address
- inst_addr_ok  out  1  instruction request accepted
- inst_data_ok  out  1  instruction read data valid
- inst_rdata  out  32  instruction read data
- data_req  in  1  data request
- data_wr  in  1  1 = write
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte write strobes
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response (read data valid or write done)
- data_rdata  out  32  data read data
- bus_req / bus_wr / bus_size / bus_wstrb / bus_addr / bus_wdata  out  1/1/2/4/32/32  slave request
- bus_addr_ok  in  1  slave accepted request
- bus_data_ok  in  1  slave response, in request order
- bus_rdata  in  32  slave read data
- err_spurious  out  1  sticky: `bus_data_ok` arrived with no outstanding request

## Operation
- **Owner encoding:** 0 = inst, 1 = data.
- **Grant when unlocked:** data has priority. `grant = data_req ? 1 : 0`.
- **Lock:**
  - Set `lock_valid`/`lock_owner` when `bus_req && !bus_addr_ok`.
  - While locked, grant = `lock_owner`. No re-arbitration happens, even if the other side raises req.
  - Cleared on `bus_addr_ok`.
- **Requester rule:** a requester holds req and all request fields stable until its `addr_ok`.
- **Bus muxing:**
  - `bus_req = (granted side's req) && !full && !reset`.
  - Request fields come from the granted side.
  - For inst: `bus_wr = 0`, `bus_size = 2`, `bus_wstrb = 0`, `bus_wdata = 0`.
- **addr_ok routing:**
  - `inst_addr_ok = bus_addr_ok && bus_req && grant == 0`.
  - `data_addr_ok` is the same with `grant == 1`.
- **Owner FIFO:**
  - Depth MAX_OUTSTANDING, wrapping log2 pointers, count of width log2(MAX_OUTSTANDING) + 1.
  - Push `grant` on `bus_req && bus_addr_ok`.
  - Pop on `bus_data_ok` when count ≠ 0.
- **data_ok routing:**
  - `inst_data_ok = bus_data_ok && count != 0 && head == 0`.
  - `data_data_ok` is the same with `head == 1`.
  - `bus_rdata` fans out to both rdata outputs unmodified.
- **Full** (`count == MAX_OUTSTANDING`): `bus_req` forced 0. Neither `addr_ok` can assert. The lock is retained.
- **Simultaneous push and pop:** count is unchanged and both pointers advance. Pushing while full is impossible because `bus_req` is 0. A pop in a full cycle frees a slot for the next cycle only; there is no same-cycle bypass.
- **Empty + `bus_data_ok`:** no routing, no pop, `err_spurious` set to 1. It is cleared only by reset.
- **Branch flush upstream:** the arbiter does not cancel anything. Every accepted request gets its `data_ok` routed back; discarding stale data is the requester's job.

## Timing
- Arbitration, muxing and response routing are combinational. The arbiter adds zero cycles to request or response latency.
- A request accepted in cycle N can be answered by `bus_data_ok` in cycle N+1 or later, never in cycle N.
- **During reset / reset values:**
  - `bus_req` = 0, `inst_addr_ok` = `data_addr_ok` = 0.
  - `inst_data_ok` = `data_data_ok` = 0 (count forced 0).
  - `err_spurious` = 0.
  - Lock, FIFO pointers and count are cleared on the reset cycle.
- **Reset mid-transaction:** all outstanding state is discarded. The slave is reset in the same cycle.
- **Throughput:** one accepted request per cycle when the slave asserts `bus_addr_ok` every cycle and the FIFO is not full.

## Test plan
- **Single inst read:** `inst_req = 1`, `inst_addr = 0x1c000000`, slave gives `addr_ok` at cycle 0 and `data_ok` at cycle 2 with `rdata = 0x02800c21`. Expect `inst_addr_ok` at cycle 0, `inst_data_ok` at cycle 2 with that data, and `data_data_ok` never asserted.
- **Contention:** both requesting at cycle 0, slave `addr_ok` every cycle. Expect data granted at cycle 0 with `bus_size` and `bus_wstrb` passed through (e.g. write `0xf` to `0x1c008000`), then inst at cycle 1. Responses in order route to data then inst.
- **Lock hold:** inst granted and `bus_addr_ok` held low 3 cycles, `data_req` rises at cycle 1. Expect `bus_addr` to stay at the inst address through cycle 3 and the data request granted at cycle 4.
- **Full:** MAX_OUTSTANDING = 4, four accepted inst reads, no `data_ok`. Expect `bus_req` = 0 on the fifth cycle. Asserting one `bus_data_ok` re-enables `bus_req` on the next cycle.
- **Spurious response:** `bus_data_ok` with count 0. Expect `err_spurious` = 1 from the next cycle onward, with neither `data_ok` output asserted.
- **Reset mid-operation:** 2 outstanding requests, then reset. Expect count = 0 and `bus_req` = 0, and the next request after reset to be handled normally.
